uart_cmd_ctrl: RTL and testbench

- Command sequencer between the UART receiver and the SDRAM controller.
- Consumes the received byte stream (rx_data qualified by po_flag) and parses fixed-format frames into single-burst write or read requests toward the SDRAM controller.
- Holds each request until the SDRAM side acknowledges it, aborts stalled frames by timeout, and flags protocol errors.

---
 rtl/uart_cmd_ctrl_pkg.sv | 13 +
 rtl/uart_cmd_ctrl.sv | 125 ++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg: shared state encoding and command byte constants for the UART command sequencer.
package uart_cmd_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_DATA,
    S_WR_REQ,
    S_RD_REQ
  } state_t;
  localparam logic [7:0] CMD_WR_BYTE = 8'h55;
  localparam logic [7:0] CMD_RD_BYTE = 8'hAA;
endpackage

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses UART byte frames into held SDRAM write/read burst requests with timeout and error reporting.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter int         BURST_LEN = 4,
  parameter int         TIMEOUT   = 1200,
  parameter logic [7:0] CMD_WR    = CMD_WR_BYTE,
  parameter logic [7:0] CMD_RD    = CMD_RD_BYTE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   po_flag,
  output logic                   wr_req,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [8*BURST_LEN-1:0] wr_data,
  input  logic                   wr_ack,
  output logic                   rd_req,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic                   rd_ack,
  output logic                   busy,
  output logic                   frame_err
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int IW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] ILAST = IW'(BURST_LEN - 1);
  state_t                 state_q, state_d;
  logic                   op_wr_q, op_wr_d;
  logic [7:0]             hi_q, hi_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [8*BURST_LEN-1:0] wr_data_q, wr_data_d;
  logic                   in_frame;
  assign in_frame  = state_q inside {S_ADDR_H, S_ADDR_L, S_DATA};
  assign wr_req    = state_q == S_WR_REQ;
  assign rd_req    = state_q == S_RD_REQ;
  assign busy      = state_q != S_IDLE;
  assign frame_err = err_q;
  assign wr_addr   = wr_addr_q;
  assign rd_addr   = rd_addr_q;
  assign wr_data   = wr_data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_wr_q   <= 1'b0;
      hi_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      hi_q      <= hi_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    hi_d      = hi_q;
    idx_d     = idx_q;
    cnt_d     = '0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: if (po_flag) begin
        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
          op_wr_d = rx_data == CMD_WR;
          state_d = S_ADDR_H;
        end else err_d = 1'b1;
      end
      S_ADDR_H: if (po_flag) begin
        hi_d    = rx_data;
        state_d = S_ADDR_L;
      end
      S_ADDR_L: if (po_flag) begin
        if (op_wr_q) begin
          wr_addr_d = ADDR_W'({hi_q, rx_data});
          idx_d     = '0;
          state_d   = S_DATA;
        end else begin
          rd_addr_d = ADDR_W'({hi_q, rx_data});
          state_d   = S_RD_REQ;
        end
      end
      S_DATA: if (po_flag) begin
        wr_data_d[8*idx_q +: 8] = rx_data;
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == ILAST ? S_WR_REQ : S_DATA;
      end
      S_WR_REQ: begin
        err_d   = po_flag;
        state_d = wr_ack ? S_IDLE : S_WR_REQ;
      end
      S_RD_REQ: begin
        err_d   = po_flag;
        state_d = rd_ack ? S_IDLE : S_RD_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    // a byte arriving on the expiry cycle takes priority over the timeout
    if (in_frame && !po_flag) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == TMAX) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed frames checked every cycle against a byte-queue model of the frame protocol.
module tb_uart_cmd_ctrl;
  localparam int TIMEOUT = 1200;
  localparam int BL = 4;
  logic        clk = 1'b0, rst = 1'b1, po_flag = 1'b0, wr_ack = 1'b0, rd_ack = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        wr_req, rd_req, busy, frame_err;
  logic [15:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  uart_cmd_ctrl #(.ADDR_W(16), .BURST_LEN(BL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .po_flag(po_flag),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .busy(busy), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [7:0]  fb[$];
  int          silent = 0;
  bit          m_wr = 0, m_rd = 0, m_err = 0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_data = '0;
  always @(posedge clk) begin
    m_err = 1'b0;
    if (rst) begin
      fb.delete();
      silent = 0;
      m_wr = 0;
      m_rd = 0;
    end else if (m_wr || m_rd) begin
      m_err = po_flag;
      if (m_wr ? wr_ack : rd_ack) begin
        m_wr = 0;
        m_rd = 0;
      end
    end else if (fb.size() == 0) begin
      if (po_flag) begin
        if (rx_data == 8'h55 || rx_data == 8'hAA) begin
          fb.push_back(rx_data);
          silent = 0;
        end else m_err = 1'b1;
      end
    end else if (po_flag) begin
      fb.push_back(rx_data);
      silent = 0;
      if (fb.size() == (fb[0] == 8'hAA ? 3 : 3 + BL)) begin
        m_addr = {fb[1], fb[2]};
        m_wr = fb[0] == 8'h55;
        m_rd = !m_wr;
        if (m_wr) for (int i = 0; i < BL; i++) m_data[8*i +: 8] = fb[3+i];
        fb.delete();
      end
    end else if (silent == TIMEOUT - 1) begin
      m_err = 1'b1;
      fb.delete();
      silent = 0;
    end else silent++;
  end
  always @(negedge clk) if (chk_en) begin
    chk("wr_req", wr_req, m_wr);
    chk("rd_req", rd_req, m_rd);
    chk("busy", busy, m_wr || m_rd || fb.size() > 0);
    chk("frame_err", frame_err, m_err);
    if (m_wr) begin
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, m_data);
    end
    if (m_rd) chk("rd_addr", rd_addr, m_addr);
  end
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    po_flag = 1'b1;
    cycle();
    po_flag = 1'b0;
  endtask
  initial begin
    logic [7:0] f_wr[7] = '{8'h55, 8'h12, 8'h34, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] f_w2[7] = '{8'h55, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] f_w3[7] = '{8'h55, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] f_w4[7] = '{8'h55, 8'h0F, 8'hF0, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst wr_req", wr_req, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst wr_data", wr_data, 0);
    chk_en = 1'b1;
    foreach (f_wr[i]) begin
      send(f_wr[i]);
      if (i == 3) repeat (2) cycle();
    end
    chk("wr latency", wr_req, 1);
    chk("wr_addr lit", wr_addr, 16'h1234);
    chk("wr_data lit", wr_data, 32'hD4C3B2A1);
    repeat (5) cycle();
    chk("wr hold", wr_req, 1);
    chk("wr_data hold", wr_data, 32'hD4C3B2A1);
    wr_ack = 1'b1;
    cycle();
    wr_ack = 1'b0;
    chk("wr drop", wr_req, 0);
    chk("wr busy drop", busy, 0);
    rd_ack = 1'b1;
    send(8'hAA);
    send(8'h00);
    send(8'h80);
    chk("rd latency", rd_req, 1);
    chk("rd_addr lit", rd_addr, 16'h0080);
    cycle();
    rd_ack = 1'b0;
    chk("rd one cycle", rd_req, 0);
    send(8'h3C);
    chk("bad cmd err", frame_err, 1);
    chk("bad cmd idle", busy, 0);
    cycle();
    chk("bad cmd pulse", frame_err, 0);
    foreach (f_w2[i]) send(f_w2[i]);
    chk("w2 data lit", wr_data, 32'h04030201);
    wr_ack = 1'b1;
    cycle();
    wr_ack = 1'b0;
    send(8'h55);
    send(8'h12);
    repeat (TIMEOUT - 1) cycle();
    chk("pre-timeout err", frame_err, 0);
    chk("pre-timeout busy", busy, 1);
    cycle();
    chk("timeout err", frame_err, 1);
    chk("timeout busy", busy, 0);
    send(8'hAA);
    repeat (TIMEOUT - 1) cycle();
    send(8'h00);
    chk("byte wins err", frame_err, 0);
    chk("byte wins busy", busy, 1);
    send(8'h01);
    chk("rd after to", rd_req, 1);
    chk("rd_addr 0001", rd_addr, 16'h0001);
    rd_ack = 1'b1;
    cycle();
    rd_ack = 1'b0;
    foreach (f_w3[i]) send(f_w3[i]);
    send(8'h99);
    chk("overrun err", frame_err, 1);
    chk("overrun req", wr_req, 1);
    chk("overrun data", wr_data, 32'h44332211);
    rx_data = 8'h77;
    po_flag = 1'b1;
    wr_ack = 1'b1;
    cycle();
    po_flag = 1'b0;
    wr_ack = 1'b0;
    chk("ovr+ack err", frame_err, 1);
    chk("ovr+ack req", wr_req, 0);
    chk("ovr+ack data", wr_data, 32'h44332211);
    cycle();
    chk("ovr idle", busy, 0);
    send(8'h55);
    send(8'hAB);
    send(8'hCD);
    send(8'h01);
    send(8'h02);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid rst busy", busy, 0);
    chk("mid rst wr_addr", wr_addr, 0);
    chk("mid rst rd_addr", rd_addr, 0);
    chk("mid rst wr_data", wr_data, 0);
    foreach (f_w4[i]) send(f_w4[i]);
    chk("post rst addr", wr_addr, 16'h0FF0);
    chk("post rst data", wr_data, 32'hEFBEADDE);
    wr_ack = 1'b1;
    cycle();
    wr_ack = 1'b0;
    repeat (3) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
